// File: rtl/outer_product_accumulator.sv
// Tiled fixed-point outer-product engine: result[i][j] = a[i]*b[j], optionally accumulated
// into the stored result, with per-cell saturation (or wrap) and a sticky overflow flag.
`timescale 1ns/1ps
module outer_product_accumulator #(
    parameter int unsigned A_LEN          = 5,
    parameter int unsigned B_LEN          = 5,
    parameter int unsigned A_WIDTH        = 8,
    parameter int unsigned B_WIDTH        = 8,
    parameter int unsigned RESULT_WIDTH   = 8,
    parameter int unsigned FRACTION_WIDTH = 4,
    parameter int unsigned TILING_V       = 1,
    parameter int unsigned TILING_H       = 1,
    parameter int unsigned SATURATE       = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic                                  accumulate,
    input  logic [A_LEN*A_WIDTH-1:0]              a,
    input  logic [B_LEN*B_WIDTH-1:0]              b,
    output logic                                  busy,
    output logic [A_LEN*B_LEN*RESULT_WIDTH-1:0]   result,
    output logic                                  valid,
    output logic                                  error
);

    localparam int unsigned VT  = (A_LEN + TILING_V - 1) / TILING_V;
    localparam int unsigned HT  = (B_LEN + TILING_H - 1) / TILING_H;
    localparam int unsigned CVW = (VT > 1) ? $clog2(VT) : 1;
    localparam int unsigned CHW = (HT > 1) ? $clog2(HT) : 1;
    localparam int unsigned RW  = RESULT_WIDTH;
    localparam int unsigned PW  = A_WIDTH + B_WIDTH;
    localparam int unsigned SW  = PW + 1;

    localparam logic [CVW-1:0] CvLast = CVW'(VT - 1);
    localparam logic [CHW-1:0] ChLast = CHW'(HT - 1);

    localparam logic signed [SW-1:0] SMax = {{(SW - RW + 1){1'b0}}, {(RW - 1){1'b1}}};
    localparam logic signed [SW-1:0] SMin = {{(SW - RW + 1){1'b1}}, {(RW - 1){1'b0}}};

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e                            state_q, state_d;
    logic [A_LEN*A_WIDTH-1:0]          a_q, a_d;
    logic [B_LEN*B_WIDTH-1:0]          b_q, b_d;
    logic                              acc_q, acc_d;
    logic [CVW-1:0]                    counter_v_q, counter_v_d;
    logic [CHW-1:0]                    counter_h_q, counter_h_d;
    logic [A_LEN*B_LEN*RW-1:0]         result_q, result_d;
    logic                              valid_q, valid_d;
    logic                              error_q, error_d;

    // Returns {overflow, new_cell}. The product is floored by the arithmetic shift.
    function automatic logic [RW:0] cell_update(input logic [A_WIDTH-1:0] av,
                                                input logic [B_WIDTH-1:0] bv,
                                                input logic [RW-1:0]      old,
                                                input logic               acc);
        logic signed [PW-1:0] a_ext;
        logic signed [PW-1:0] b_ext;
        logic signed [PW-1:0] prod;
        logic signed [PW-1:0] p;
        logic signed [SW-1:0] old_ext;
        logic signed [SW-1:0] s;
        logic                 ovf;
        logic [RW-1:0]        val;
        a_ext   = $signed({{B_WIDTH{av[A_WIDTH-1]}}, av});
        b_ext   = $signed({{A_WIDTH{bv[B_WIDTH-1]}}, bv});
        prod    = a_ext * b_ext;
        p       = prod >>> FRACTION_WIDTH;
        old_ext = $signed({{(SW - RW){old[RW-1]}}, old});
        s       = $signed({p[PW-1], p});
        if (acc) begin
            s = s + old_ext;
        end
        ovf = (s > SMax) || (s < SMin);
        val = s[RW-1:0];
        if (ovf && (SATURATE != 0)) begin
            val = s[SW-1] ? SMin[RW-1:0] : SMax[RW-1:0];
        end
        return {ovf, val};
    endfunction

    always_comb begin
        int          row;
        int          col;
        logic [RW:0] upd;
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        counter_v_d = counter_v_q;
        counter_h_d = counter_h_q;
        result_d    = result_q;
        valid_d     = valid_q;
        error_d     = error_q;
        row         = 0;
        col         = 0;
        upd         = '0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d     = StRun;
                    a_d         = a;
                    b_d         = b;
                    acc_d       = accumulate;
                    valid_d     = 1'b0;
                    error_d     = 1'b0;
                    counter_v_d = '0;
                    counter_h_d = '0;
                end
            end
            StRun: begin
                for (int k = 0; k < int'(TILING_V); k++) begin
                    for (int l = 0; l < int'(TILING_H); l++) begin
                        row = int'(counter_v_q) * int'(TILING_V) + k;
                        col = int'(counter_h_q) * int'(TILING_H) + l;
                        // Lanes past the matrix edge on a partial tile are simply idle.
                        if ((row < int'(A_LEN)) && (col < int'(B_LEN))) begin
                            upd = cell_update(a_q[row*A_WIDTH +: A_WIDTH],
                                              b_q[col*B_WIDTH +: B_WIDTH],
                                              result_q[(row*B_LEN + col)*RW +: RW],
                                              acc_q);
                            result_d[(row*B_LEN + col)*RW +: RW] = upd[RW-1:0];
                            if (upd[RW]) begin
                                error_d = 1'b1;
                            end
                        end
                    end
                end
                if ((counter_v_q == CvLast) && (counter_h_q == ChLast)) begin
                    valid_d = 1'b1;
                    state_d = StIdle;
                end else if (counter_h_q == ChLast) begin
                    counter_h_d = '0;
                    counter_v_d = counter_v_q + CVW'(1);
                end else begin
                    counter_h_d = counter_h_q + CHW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= 1'b0;
            counter_v_q <= '0;
            counter_h_q <= '0;
            result_q    <= '0;
            valid_q     <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            counter_v_q <= counter_v_d;
            counter_h_q <= counter_h_d;
            result_q    <= result_d;
            valid_q     <= valid_d;
            error_q     <= error_d;
        end
    end

    assign busy   = (state_q == StRun);
    assign result = result_q;
    assign valid  = valid_q;
    assign error  = error_q;

endmodule
